// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding, owner IDs
// and the data-path widths that are fixed by the memory interface.
package mem_arb_pkg;

  localparam int DW = 32;  // memory word width
  localparam int BW = 4;   // byte-enable lanes per word

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // The port that did not own the previous access; used to break ties.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_C) ? OWN_D : OWN_C;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker. A single requester is granted directly; when
// both request, the port that did not own the last access wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   c_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_id
);

  // Grant decode: purely combinational, evaluated only while the FSM idles.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = c_req | d_req;
    grant_id    = OWN_C;
    if (c_req && d_req) begin
      grant_id = other_owner(last_owner);
    end else if (d_req) begin
      grant_id = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous word memory between the processor
// controller (port C) and the debug/program loader (port D). Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK, so one access takes
// MEM_LAT+3 cycles including the IDLE cycle that samples the request.
// Every output is a register or a decode of the state register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 10,
  parameter int MEM_LAT = 1,   // 1..15, issue cycle to valid m_rdata
  parameter int CW      = 4    // must hold MEM_LAT-1
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          c_req,
  input  logic          c_we,
  input  logic [BW-1:0] c_be,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [BW-1:0] d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,

  output logic          m_en,
  output logic          m_we,
  output logic [BW-1:0] m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,

  output logic          busy
);

  state_t        state;
  owner_t        owner;       // port that owns the access in flight
  owner_t        last_owner;  // owner of the most recently acked access
  logic          req_we;      // latched direction of the access in flight
  logic [CW-1:0] cnt;         // remaining WAIT cycles before m_rdata is valid

  logic          grant_valid;
  owner_t        grant_id;

  logic          sel_we;
  logic [BW-1:0] sel_be;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  mem_arb_rr u_rr (
    .c_req       (c_req),
    .d_req       (d_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Route the granted port's request fields toward the request registers.
  always_comb begin
    sel_we    = c_we;
    sel_be    = c_be;
    sel_addr  = c_addr;
    sel_wdata = c_wdata;
    if (grant_id == OWN_D) begin
      sel_we    = d_we;
      sel_be    = d_be;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
  end

  // Access sequencer: owns the state, latency counter, request registers,
  // memory strobes, per-port read data and ack pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_C;
      last_owner <= OWN_D;
      req_we     <= 1'b0;
      cnt        <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees the pre-edge value.
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= grant_id;
            req_we  <= sel_we;
            m_en    <= 1'b1;
            m_we    <= sel_we;
            m_be    <= sel_be;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // The strobe lasts exactly one cycle; address and data stay latched.
          m_en  <= 1'b0;
          m_we  <= 1'b0;
          cnt   <= CW'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            if (!req_we) begin
              if (owner == OWN_C) c_rdata <= m_rdata;
              else                d_rdata <= m_rdata;
            end
            if (owner == OWN_C) c_ack <= 1'b1;
            else                d_ack <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=4), each with a
// behavioural RAM. Expectations come from a word-array memory model and the
// round-robin rule; every step is checked at the falling edge.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic clk;
  logic reset;

  logic          c_req [2];
  logic          c_we  [2];
  logic [3:0]    c_be  [2];
  logic [AW-1:0] c_addr[2];
  logic [31:0]   c_wdata[2];
  logic [31:0]   c_rdata[2];
  logic          c_ack [2];
  logic          d_req [2];
  logic          d_we  [2];
  logic [3:0]    d_be  [2];
  logic [AW-1:0] d_addr[2];
  logic [31:0]   d_wdata[2];
  logic [31:0]   d_rdata[2];
  logic          d_ack [2];
  logic          m_en  [2];
  logic          m_we  [2];
  logic [3:0]    m_be  [2];
  logic [AW-1:0] m_addr[2];
  logic [31:0]   m_wdata[2];
  logic [31:0]   m_rdata[2];
  logic          busy  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.AW(AW), .MEM_LAT(g == 0 ? 1 : 4), .CW(4)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .c_req   (c_req[g]),
      .c_we    (c_we[g]),
      .c_be    (c_be[g]),
      .c_addr  (c_addr[g]),
      .c_wdata (c_wdata[g]),
      .c_rdata (c_rdata[g]),
      .c_ack   (c_ack[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we[g]),
      .d_be    (d_be[g]),
      .d_addr  (d_addr[g]),
      .d_wdata (d_wdata[g]),
      .d_rdata (d_rdata[g]),
      .d_ack   (d_ack[g]),
      .m_en    (m_en[g]),
      .m_we    (m_we[g]),
      .m_be    (m_be[g]),
      .m_addr  (m_addr[g]),
      .m_wdata (m_wdata[g]),
      .m_rdata (m_rdata[g]),
      .busy    (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int g, input int a);
    if (a == 4) return 32'h1234_5678;
    return (32'(a + 1) * 32'h9E37_79B9) ^ 32'(g << 28);
  endfunction

  // ---------------- behavioural RAM (environment) ----------------
  logic [31:0] ram [2][NW];
  bit          ram_init_done = 1'b0;
  logic [3:0][31:0] pipe0;
  logic [3:0][31:0] pipe1;

  assign m_rdata[0] = pipe0[0];
  assign m_rdata[1] = pipe1[3];

  // Read data enters a delay line; non-read cycles feed random junk so a
  // capture at the wrong cycle returns garbage.
  function automatic logic [31:0] next_word(input int g);
    if (m_en[g] && !m_we[g]) return ram[g][m_addr[g]];
    return $urandom;
  endfunction

  task automatic mem_write(input int g);
    if (m_en[g] && m_we[g]) begin
      for (int b = 0; b < 4; b++) begin
        if (m_be[g][b]) ram[g][m_addr[g]][8*b +: 8] = m_wdata[g][8*b +: 8];
      end
    end
  endtask

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int g = 0; g < 2; g++)
        for (int a = 0; a < NW; a++) ram[g][a] = init_word(g, a);
      ram_init_done = 1'b1;
    end
    pipe0 <= {pipe0[2:0], next_word(0)};
    pipe1 <= {pipe1[2:0], next_word(1)};
    mem_write(0);
    mem_write(1);
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [2][NW];
  bit          last_own [2];     // 0 = port C, 1 = port D
  logic [31:0] exp_rd [2][2];    // [instance][port]

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          on;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
  } acc_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk(input bit on, input bit we, input logic [3:0] be,
                              input logic [AW-1:0] addr, input logic [31:0] wd);
    acc_t a;
    a.on = on; a.we = we; a.be = be; a.addr = addr; a.wd = wd;
    return a;
  endfunction

  function automatic acc_t rand_acc(input bit on);
    logic [AW-1:0] addr;
    addr = ($urandom_range(0, 3) == 0) ? '1 : AW'($urandom_range(0, 7));
    return mk(on, 1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom);
  endfunction

  function automatic logic ack_of(input int k, input int p);
    return (p == 1) ? d_ack[k] : c_ack[k];
  endfunction

  function automatic logic [31:0] rd_of(input int k, input int p);
    return (p == 1) ? d_rdata[k] : c_rdata[k];
  endfunction

  task automatic drive(input int k, input int p, input acc_t a);
    if (p == 0) begin
      c_req[k] = a.on; c_we[k] = a.we; c_be[k] = a.be; c_addr[k] = a.addr; c_wdata[k] = a.wd;
    end else begin
      d_req[k] = a.on; d_we[k] = a.we; d_be[k] = a.be; d_addr[k] = a.addr; d_wdata[k] = a.wd;
    end
  endtask

  task automatic drop(input int k, input int p);
    if (p == 0) c_req[k] = 1'b0;
    else        d_req[k] = 1'b0;
  endtask

  // Model-side effect of one completed access.
  task automatic model_apply(input int k, input int p, input acc_t a);
    if (a.we) begin
      for (int b = 0; b < 4; b++)
        if (a.be[b]) ref_mem[k][a.addr][8*b +: 8] = a.wd[8*b +: 8];
    end else begin
      exp_rd[k][p] = ref_mem[k][a.addr];
    end
    last_own[k] = (p == 1);
  endtask

  // Raise the requested ports at the current falling edge and follow every
  // access cycle by cycle; ends at a falling edge inside an IDLE cycle.
  task automatic run_round(input int k, input acc_t a_c, input acc_t a_d);
    int   lat = (k == 0) ? 1 : 4;
    int   n   = 0;
    int   ord [2];
    acc_t acc [2];
    acc[0] = a_c;
    acc[1] = a_d;
    if (a_c.on && a_d.on) begin
      ord[0] = last_own[k] ? 0 : 1;
      ord[1] = 1 - ord[0];
      n = 2;
    end else if (a_c.on) begin
      ord[0] = 0; n = 1;
    end else if (a_d.on) begin
      ord[0] = 1; n = 1;
    end
    drive(k, 0, a_c);
    drive(k, 1, a_d);
    for (int i = 0; i < n; i++) begin
      int p = ord[i];
      @(negedge clk);
      chk($sformatf("k%0d p%0d issue m_en", k, p), 32'(m_en[k]), 32'd1);
      chk($sformatf("k%0d p%0d issue m_we", k, p), 32'(m_we[k]), 32'(acc[p].we));
      chk($sformatf("k%0d p%0d issue m_be", k, p), 32'(m_be[k]), 32'(acc[p].be));
      chk($sformatf("k%0d p%0d issue m_addr", k, p), 32'(m_addr[k]), 32'(acc[p].addr));
      chk($sformatf("k%0d p%0d issue m_wdata", k, p), m_wdata[k], acc[p].wd);
      model_apply(k, p, acc[p]);
      for (int w = 0; w < lat; w++) begin
        @(negedge clk);
        chk($sformatf("k%0d p%0d wait%0d en/acks/busy", k, p, w),
            {28'd0, m_en[k], c_ack[k], d_ack[k], busy[k]}, 32'b0001);
      end
      @(negedge clk);
      chk($sformatf("k%0d p%0d ack owner", k, p), 32'(ack_of(k, p)), 32'd1);
      chk($sformatf("k%0d p%0d ack other", k, p), 32'(ack_of(k, 1 - p)), 32'd0);
      chk($sformatf("k%0d p%0d ack m_en", k, p), 32'(m_en[k]), 32'd0);
      chk($sformatf("k%0d p%0d rdata owner", k, p), rd_of(k, p), exp_rd[k][p]);
      chk($sformatf("k%0d p%0d rdata other", k, p), rd_of(k, 1 - p), exp_rd[k][1 - p]);
      drop(k, p);
      @(negedge clk);
      chk($sformatf("k%0d p%0d idle en/acks/busy", k, p),
          {28'd0, m_en[k], c_ack[k], d_ack[k], busy[k]}, 32'b0000);
    end
  endtask

  task automatic chk_reset_vals(input string tag, input int k);
    chk({tag, " m_en/m_we/acks/busy"},
        {27'd0, m_en[k], m_we[k], c_ack[k], d_ack[k], busy[k]}, 32'd0);
    chk({tag, " m_be"}, 32'(m_be[k]), 32'd0);
    chk({tag, " m_addr"}, 32'(m_addr[k]), 32'd0);
    chk({tag, " m_wdata"}, m_wdata[k], 32'd0);
    chk({tag, " c_rdata"}, c_rdata[k], 32'd0);
    chk({tag, " d_rdata"}, d_rdata[k], 32'd0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_own[k]  = 1'b1;
      exp_rd[k][0] = '0;
      exp_rd[k][1] = '0;
    end
  endtask

  initial begin
    logic [31:0] w;
    int          s;
    acc_t        off;
    off = mk(0, 0, 4'h0, '0, '0);

    for (int k = 0; k < 2; k++) begin
      drive(k, 0, off);
      drive(k, 1, off);
      for (int a = 0; a < NW; a++) ref_mem[k][a] = init_word(k, a);
    end
    model_reset();

    // Power-on reset.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("por k0", 0);
    chk_reset_vals("por k1", 1);
    reset = 1'b0;
    @(negedge clk);

    // C read of word 4 with MEM_LAT=1.
    run_round(0, mk(1, 0, 4'hF, 10'h004, 32'h0), off);
    chk("tp1 c_rdata", c_rdata[0], 32'h1234_5678);

    // D byte-lane write to the top address, then C reads it back.
    run_round(0, off, mk(1, 1, 4'b0001, 10'h3FF, 32'hDEAD_BEEF));
    run_round(0, mk(1, 0, 4'hF, 10'h3FF, 32'h0), off);
    w = init_word(0, 10'h3FF);
    chk("tp2 c_rdata", c_rdata[0], {w[31:8], 8'hEF});

    // Write with no byte lanes enabled still runs a full access.
    run_round(0, mk(1, 1, 4'b0000, 10'h004, 32'hFFFF_FFFF), off);
    run_round(0, off, mk(1, 0, 4'hF, 10'h004, 32'h0));
    chk("be0 d_rdata", d_rdata[0], 32'h1234_5678);

    // Both ports requesting every round: grants alternate.
    for (int r = 0; r < 3; r++)
      run_round(0, mk(1, 0, 4'hF, AW'(r), 32'h0), mk(1, 0, 4'hF, AW'(r + 8), 32'h0));

    // Requester holds req through the cycle after ack: a second access issues.
    drive(0, 0, mk(1, 0, 4'hF, 10'h005, 32'h0));
    repeat (3) @(negedge clk);
    chk("hold first ack", 32'(c_ack[0]), 32'd1);
    @(negedge clk);
    chk("hold idle gap", {30'd0, c_ack[0], m_en[0]}, 32'd0);
    @(negedge clk);
    chk("hold second issue", 32'(m_en[0]), 32'd1);
    chk("hold second addr", 32'(m_addr[0]), 32'h005);
    drop(0, 0);
    repeat (2) @(negedge clk);
    chk("hold second ack", 32'(c_ack[0]), 32'd1);
    chk("hold second rdata", c_rdata[0], ref_mem[0][5]);
    last_own[0] = 1'b0;
    exp_rd[0][0] = ref_mem[0][5];
    @(negedge clk);

    // MEM_LAT=4: read captured exactly at the last WAIT cycle.
    run_round(1, mk(1, 0, 4'hF, 10'h004, 32'h0), off);
    chk("lat4 c_rdata", c_rdata[1], 32'h1234_5678);

    // Randomised traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 25; r++) begin
        s = $urandom_range(1, 3);
        run_round(k, rand_acc((s & 1) != 0), rand_acc((s & 2) != 0));
      end
    end

    // Reset during WAIT of a D read: everything clears at once, no ack.
    drive(1, 1, mk(1, 0, 4'hF, 10'h006, 32'h0));
    repeat (2) @(negedge clk);
    chk("rst pre busy", 32'(busy[1]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("rst async k1", 1);
    chk_reset_vals("rst async k0", 0);
    drop(1, 1);
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst no d_ack %0d", c), 32'(d_ack[1]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    run_round(1, mk(1, 0, 4'hF, 10'h001, 32'h0), mk(1, 0, 4'hF, 10'h002, 32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous word memory between two requesters: port C (processor multi-cycle controller, for fetch, lw/sw, lb/sb) and port D (debug/program loader).
- Sequences every access through a fixed FSM, waits for a parameterised memory latency, then returns one ack pulse and registered read data to the owner.
- Sits between the Controller/datapath memory interface and the shared RAM.

Parameters:
- AW, 10, word-address width.
- MEM_LAT, 1, cycles from the issue cycle to valid m_rdata; legal range 1..15.
- CW, 4, width of the latency counter; must hold MEM_LAT-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  port C request; held until c_ack.
- c_we  in  1  port C write (1) / read (0).
- c_be  in  4  port C byte enables, used on writes (sb uses a single lane).
- c_addr  in  AW  port C word address.
- c_wdata  in  32  port C write data.
- c_rdata  out  32  port C registered read data.
- c_ack  out  1  port C one-cycle completion pulse.
- d_req, d_we, d_be, d_addr, d_wdata, d_rdata, d_ack  same as the port C signals, for port D.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write.
- m_be  out  4  memory byte enables.
- m_addr  out  AW  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE; c_rdata=d_rdata=0; c_ack=d_ack=0; m_en=m_we=0; m_be=0; m_addr=0; m_wdata=0; last_owner=D, so port C wins the first tie.
- All outputs are registered or decoded from registered state only. No combinational path from req to m_*.
- IDLE:
  - If any req is high, choose an owner, latch that port's we/be/addr/wdata into request registers, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - m_en=1, m_we=latched we, m_be/m_addr/m_wdata = latched values.
  - Load cnt=MEM_LAT-1. Go to WAIT.
- WAIT:
  - m_en=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0 and the access is a read, capture m_rdata into the owner's rdata register at this edge. Then go to ACK.
- ACK (1 cycle):
  - Owner's ack=1. Update last_owner to the owner. Go to IDLE.
- Latency per access is MEM_LAT+3 cycles from the IDLE cycle that sees req to the ack cycle, inclusive. With MEM_LAT=1 this is 4 cycles.
- Arbitration:
  - Only one req high: grant it.
  - Both high in IDLE: grant the port that is not last_owner (2-way round robin). Neither port can starve.
- req is sampled only in IDLE. Changes to req, addr or data during ISSUE/WAIT/ACK are ignored.
- The requester must drop req the cycle after ack. A req still high in the next IDLE is treated as a new request.
- Writes:
  - c_rdata/d_rdata are not modified; they hold the last read value until the next read completes for that port.
  - The ack timing is identical to reads.
  - be=0000 on a write still performs a full ISSUE/WAIT/ACK; the memory changes nothing.
- Reads drive m_be with the latched be, but m_be has no effect on reads.
- Only one access is in flight at any time; m_en is never asserted in two consecutive cycles.
- Asserting reset mid-operation returns everything to reset values immediately. The in-flight access is abandoned with no ack, and the requester must re-request.
- The address is used modulo 2^AW; there is no alignment check (byte selection is via be).

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3;
  - owner IDs OWN_C=1'b0, OWN_D=1'b1.
- One sub-module, mem_arb_rr: 2-way round-robin picker. Inputs: c_req, d_req, last_owner. Outputs: grant_valid, grant_id. Purely combinational.
- The FSM, counter and request/rdata registers stay in mem_arbiter.

Test Plan:
- MEM_LAT=1. C read at addr 0x004, memory holds 0x12345678 -> m_en high for exactly 1 cycle with m_addr=0x004, m_we=0; c_ack 3 cycles after ISSUE (4 cycles after req seen); c_rdata=0x12345678; d_ack never pulses.
- D write addr 0x3FF, wdata 0xDEADBEEF, be=0001, then C read addr 0x3FF -> m_be=0001 on the write; the read returns 0x000000EF in the low byte with the other bytes unchanged; d_rdata holds its previous value.
- c_req and d_req both high continuously after reset -> grants alternate C, D, C, D; ack pulses alternate; no two consecutive m_en cycles.
- MEM_LAT=4. C read -> WAIT lasts 4 cycles; c_rdata is captured from m_rdata at the 4th cycle after ISSUE; ack follows one cycle later.
- reset asserted during WAIT of a D read -> all outputs 0 asynchronously; no d_ack; after release, C wins the tie when both request.
- Requester keeps req high one cycle after ack -> a second access is issued, confirming the drop-req-after-ack rule.
